// File: rtl/struct_enum_pkg.sv
// Shared types and constants for the struct/enum transaction engine.
package struct_enum_pkg;

  localparam int          AW       = 8;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 256;
  localparam logic [31:0] ERR_DATA = 32'hBAD0_BAD0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
  } transaction_s;

  typedef struct packed {
    transaction_s request;
    transaction_s response;
    logic [3:0]   id;
  } bus_packet_s;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2,
    ERROR  = 2'd3
  } state_e;

  // Encoding 3 is deliberately left unnamed: it is the illegal command.
  typedef enum logic [1:0] {
    CMD_READ  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_ERASE = 2'd2
  } command_e;

  function automatic logic cmd_legal(input logic [1:0] c);
    return (c <= 2'd2);
  endfunction

endpackage

// File: rtl/struct_enum_store.sv
// 256x32 word store: one synchronous write port, one combinational read port.
module struct_enum_store
  import struct_enum_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Reset clears every word and takes priority over a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/struct_enum_test.sv
// Single-port transaction engine: latch a request in IDLE, execute it against
// the word store in ACTIVE, present the response in WAIT until consumed.
// An illegal command parks the engine in ERROR until err_clr_i.
module struct_enum_test
  import struct_enum_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  transaction_s req_i,
  input  command_e     cmd_i,
  input  logic [3:0]   id_i,
  output logic         req_ready_o,
  input  logic         rsp_ready_i,
  output bus_packet_s  pkt_o,
  output state_e       state_o,
  output logic         error_o,
  input  logic         err_clr_i
);

  state_e        state_q, state_d;
  bus_packet_s   pkt_q;
  logic [1:0]    cmd_q;   // raw encoding, may hold the illegal value 3
  logic          st_we;
  logic [DW-1:0] st_wdata;
  logic [DW-1:0] st_rdata;

  struct_enum_store u_store (
    .clk   (clk),
    .rst   (rst),
    .we    (st_we),
    .waddr (pkt_q.request.addr),
    .wdata (st_wdata),
    .raddr (pkt_q.request.addr),
    .rdata (st_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; ACTIVE always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_i.valid) state_d = cmd_legal(cmd_i) ? ACTIVE : ERROR;
      ACTIVE:  state_d = WAIT;
      WAIT:    if (rsp_ready_i) state_d = IDLE;
      ERROR:   if (err_clr_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store write strobe: WRITE stores the latched data, ERASE stores zero.
  always_comb begin
    st_we    = 1'b0;
    st_wdata = '0;
    if (state_q == ACTIVE) begin
      case (cmd_q)
        CMD_WRITE: begin st_we = 1'b1; st_wdata = pkt_q.request.data; end
        CMD_ERASE: st_we = 1'b1;
        default:   ;
      endcase
    end
  end

  // Packet register: request capture in IDLE, response build in ACTIVE,
  // response retire in WAIT / ERROR.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q <= '0;
      cmd_q <= 2'd0;
    end else begin
      unique case (state_q)
        IDLE: if (req_i.valid) begin
          pkt_q.request <= req_i;
          pkt_q.id      <= id_i;
          cmd_q         <= cmd_i;
          if (!cmd_legal(cmd_i))
            pkt_q.response <= '{addr: '0, data: ERR_DATA, valid: 1'b1, ready: 1'b0};
        end
        ACTIVE: begin
          pkt_q.response.addr  <= pkt_q.request.addr;
          // st_wdata is the written value for WRITE and zero for ERASE
          pkt_q.response.data  <= (cmd_q == CMD_READ) ? st_rdata : st_wdata;
          pkt_q.response.valid <= 1'b1;
        end
        WAIT:  if (rsp_ready_i) pkt_q.response.valid <= 1'b0;
        ERROR: if (err_clr_i)   pkt_q.response <= '0;
        default: ;
      endcase
    end
  end

  // Output packet; response.ready follows the consumer live while in WAIT.
  always_comb begin
    pkt_o = pkt_q;
    if (state_q == WAIT) pkt_o.response.ready = rsp_ready_i;
  end

  assign state_o     = state_q;
  assign error_o     = (state_q == ERROR);
  assign req_ready_o = (state_q == IDLE);

endmodule

// File: tb/tb_struct_enum_test.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences,
// then randomized transactions against a plain memory-array reference.
module tb_struct_enum_test;
  import struct_enum_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  transaction_s req_i;
  command_e     cmd_i;
  logic [3:0]   id_i;
  logic         req_ready_o;
  logic         rsp_ready_i;
  bus_packet_s  pkt_o;
  state_e       state_o;
  logic         error_o;
  logic         err_clr_i;

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] ref_mem [256];

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  id;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  struct_enum_test dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .cmd_i       (cmd_i),
    .id_i        (id_i),
    .req_ready_o (req_ready_o),
    .rsp_ready_i (rsp_ready_i),
    .pkt_o       (pkt_o),
    .state_o     (state_o),
    .error_o     (error_o),
    .err_clr_i   (err_clr_i)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
  endtask

  // One complete transaction with an optional WAIT stall; exp is the
  // response data the caller requires.
  task automatic run_txn(input logic [1:0] cmd, input logic [7:0] addr,
                         input logic [31:0] data, input logic [3:0] id,
                         input logic [31:0] exp, input string tag);
    int n;
    int stall;
    n = 0;
    while (state_o != IDLE && n < 10) begin tick; n++; end
    chk({tag, "_idle"}, state_o, IDLE);
    req_i     = '{addr: addr, data: data, valid: 1'b1, ready: 1'($urandom_range(0, 1))};
    cmd_i     = command_e'(cmd);
    id_i      = id;
    err_clr_i = 1'($urandom_range(0, 1));
    tick;
    // scramble inputs: the engine must work from its latched copy
    req_i.valid = 1'b0;
    req_i.data  = $urandom;
    req_i.addr  = 8'($urandom);
    cmd_i       = command_e'(2'($urandom_range(0, 2)));
    id_i        = 4'($urandom);
    chk({tag, "_active"}, state_o, ACTIVE);
    chk({tag, "_early_valid"}, pkt_o.response.valid, 1'b0);
    tick;
    if (cmd == 2'd1) ref_mem[addr] = data;
    else if (cmd == 2'd2) ref_mem[addr] = 32'h0;
    chk({tag, "_wait"}, state_o, WAIT);
    chk({tag, "_valid"}, pkt_o.response.valid, 1'b1);
    chk({tag, "_data"}, pkt_o.response.data, exp);
    chk({tag, "_addr"}, pkt_o.response.addr, addr);
    chk({tag, "_id"}, pkt_o.id, id);
    chk({tag, "_echo"}, pkt_o.request.data, data);
    stall = $urandom_range(0, 2);
    for (int s = 0; s < stall; s++) begin
      tick;
      chk({tag, "_stall"}, {state_o, pkt_o.response.data}, {WAIT, exp});
    end
    rsp_ready_i = 1'b1;
    #1;
    chk({tag, "_rdy_mirror"}, pkt_o.response.ready, 1'b1);
    tick;
    rsp_ready_i = 1'b0;
    err_clr_i   = 1'b0;
    chk({tag, "_done"}, {state_o, pkt_o.response.valid}, {IDLE, 1'b0});
  endtask

  initial begin
    logic [1:0]  c;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] e;

    vecs[0] = '{2'd0, 8'h10, 32'h0,         4'h1, 32'h0};
    vecs[1] = '{2'd1, 8'hFF, 32'hDEADBEEF,  4'hA, 32'hDEADBEEF};
    vecs[2] = '{2'd0, 8'hFF, 32'h0,         4'h2, 32'hDEADBEEF};
    vecs[3] = '{2'd2, 8'hFF, 32'h12345678,  4'h3, 32'h0};
    vecs[4] = '{2'd0, 8'hFF, 32'h0,         4'h4, 32'h0};
    vecs[5] = '{2'd1, 8'h00, 32'h12345678,  4'hF, 32'h12345678};
    vecs[6] = '{2'd1, 8'h01, 32'hFFFFFFFF,  4'h0, 32'hFFFFFFFF};
    vecs[7] = '{2'd0, 8'h00, 32'h0,         4'h7, 32'h12345678};

    rst = 1'b1; req_i = '0; cmd_i = CMD_READ; id_i = '0;
    rsp_ready_i = 1'b0; err_clr_i = 1'b0;
    clear_model();
    tick; tick;
    rst = 1'b0;
    chk("rst_state", state_o, IDLE);
    chk("rst_pkt_zero", pkt_o == '0, 1'b1);
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_error", error_o, 1'b0);

    // Directed vectors
    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].id, vecs[i].exp, $sformatf("vec%0d", i));

    // Illegal command: sticky ERROR, immune to rsp_ready and new requests
    req_i = '{addr: 8'h33, data: 32'h11112222, valid: 1'b1, ready: 1'b0};
    cmd_i = command_e'(2'd3); id_i = 4'h5;
    tick;
    req_i.valid = 1'b0;
    chk("err_state", state_o, ERROR);
    chk("err_flag", error_o, 1'b1);
    chk("err_valid", pkt_o.response.valid, 1'b1);
    chk("err_data", pkt_o.response.data, ERR_DATA);
    chk("err_req_ready", req_ready_o, 1'b0);
    chk("err_id", pkt_o.id, 4'h5);
    rsp_ready_i = 1'b1; req_i.valid = 1'b1; cmd_i = CMD_WRITE;
    tick; tick;
    chk("err_sticky", {state_o, pkt_o.response.data}, {ERROR, ERR_DATA});
    rsp_ready_i = 1'b0; req_i.valid = 1'b0;
    err_clr_i = 1'b1;
    tick;
    err_clr_i = 1'b0;
    chk("err_clr_state", state_o, IDLE);
    chk("err_clr_flag", error_o, 1'b0);
    chk("err_clr_rsp", pkt_o.response == '0, 1'b1);
    run_txn(2'd0, 8'h33, 32'h0, 4'h6, ref_mem[8'h33], "err_untouched");

    // Requests during WAIT are dropped
    req_i = '{addr: 8'h77, data: 32'hABCD0123, valid: 1'b1, ready: 1'b0};
    cmd_i = CMD_WRITE; id_i = 4'h9;
    tick; tick;
    ref_mem[8'h77] = 32'hABCD0123;
    req_i = '{addr: 8'h77, data: 32'h0, valid: 1'b1, ready: 1'b0};
    cmd_i = CMD_ERASE; id_i = 4'h2;
    tick; tick; tick;
    chk("waitign_state", state_o, WAIT);
    chk("waitign_data", pkt_o.response.data, 32'hABCD0123);
    chk("waitign_id", pkt_o.id, 4'h9);
    rsp_ready_i = 1'b1;
    tick;
    chk("waitign_exit", state_o, IDLE);
    rsp_ready_i = 1'b0; req_i.valid = 1'b0;
    run_txn(2'd0, 8'h77, 32'h0, 4'h3, 32'hABCD0123, "waitign_rd");

    // Reset during ACTIVE aborts the write and clears the whole store
    req_i = '{addr: 8'h55, data: 32'hCAFEF00D, valid: 1'b1, ready: 1'b0};
    cmd_i = CMD_WRITE; id_i = 4'h1;
    tick;
    req_i.valid = 1'b0;
    chk("rstact_active", state_o, ACTIVE);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    clear_model();
    chk("rstact_state", state_o, IDLE);
    chk("rstact_pkt_zero", pkt_o == '0, 1'b1);
    run_txn(2'd0, 8'h55, 32'h0, 4'h4, 32'h0, "rstact_rd");
    run_txn(2'd0, 8'hFF, 32'h0, 4'h4, 32'h0, "rstact_rd2");

    // Randomized traffic over a narrow address window to force reuse
    for (int i = 0; i < 150; i++) begin
      c = 2'($urandom_range(0, 2));
      a = 8'($urandom_range(0, 15)) | ((i % 5 == 0) ? 8'hF0 : 8'h00);
      d = $urandom;
      e = (c == 2'd1) ? d : (c == 2'd2) ? 32'h0 : ref_mem[a];
      run_txn(c, a, d, 4'($urandom), e, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
